// File: rtl/reaction_stimulus_gen.sv
// ----------------------------------------------------------------------------
// reaction_stimulus_gen
//
// Front end of the reaction timer. Each arm request runs one trial. The block
// waits a pseudo-random delay and then lights the LED. It debounces the raw
// pushbutton. It brackets the reaction interval with start/stop pulses, and it
// flags presses that arrive before the LED is lit (false starts).
//
// Ports
//   clk          in   single clock domain
//   rst          in   asynchronous, active-high reset
//   arm          in   request a trial; only looked at while idle
//   button_raw   in   asynchronous pushbutton, 1 = pressed
//   led_on       out  stimulus LED, lit from start_pulse until the press is accepted
//   start_pulse  out  one-cycle pulse in the first cycle led_on is high
//   stop_pulse   out  one-cycle pulse on the accepted press while lit
//   btn_db       out  debounced button level
//   false_start  out  sticky press-during-delay flag, cleared by the next arm
//   busy         out  high whenever a trial is in progress
//
// FSM states
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_IDLE  | no trial; waiting for arm
//   ST_DELAY | counting down the random delay; a press here is a false start
//   ST_LIT   | LED lit; waiting for a fresh debounced press
// ----------------------------------------------------------------------------
module reaction_stimulus_gen #(
    parameter int unsigned DEBOUNCE_CYCLES = 8,
    parameter int unsigned DELAY_MIN       = 1000,
    parameter logic [15:0] DELAY_MASK      = 16'h0FFF
) (
    input  logic clk,
    input  logic rst,
    input  logic arm,
    input  logic button_raw,
    output logic led_on,
    output logic start_pulse,
    output logic stop_pulse,
    output logic btn_db,
    output logic false_start,
    output logic busy
);

    localparam int unsigned    DB_W      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0] DB_ONE   = DB_W'(1);
    localparam logic [15:0]    LFSR_SEED = 16'hACE1;
    localparam logic [15:0]    LFSR_TAPS = 16'hB400;
    localparam logic [16:0]    DELAY_BASE = 17'(DELAY_MIN);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_LIT   = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [15:0]     lfsr_q,        lfsr_d;
    logic            sync1_q,       sync1_d;
    logic            sync2_q,       sync2_d;
    logic [DB_W-1:0] db_cnt_q,      db_cnt_d;
    logic            btn_db_q,      btn_db_d;
    state_t          state_q,       state_d;
    logic [16:0]     dcnt_q,        dcnt_d;
    logic            led_on_q,      led_on_d;
    logic            start_pulse_q, start_pulse_d;
    logic            stop_pulse_q,  stop_pulse_d;
    logic            false_start_q, false_start_d;

    logic            press;
    logic [16:0]     delay_load;

    // ------------------------------------------------------------------
    // Free-running Galois LFSR; the seed is nonzero and the taps are
    // maximal-length, so the all-zero lock-up state is never reached.
    // ------------------------------------------------------------------
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    end

    // ------------------------------------------------------------------
    // Button synchroniser and debounce
    // ------------------------------------------------------------------
    always_comb begin
        sync1_d = button_raw;
        sync2_d = sync1_q;
    end

    // The counter holds how many consecutive cycles the synced level has
    // disagreed with the debounced level. The debounced level flips on the
    // edge where that run reaches DEBOUNCE_CYCLES, so it never stores the
    // terminal value itself.
    always_comb begin
        db_cnt_d = '0;
        btn_db_d = btn_db_q;
        if (sync2_q != btn_db_q) begin
            if (db_cnt_q == DB_LAST) begin
                btn_db_d = sync2_q;
                db_cnt_d = '0;
            end else begin
                db_cnt_d = db_cnt_q + DB_ONE;
            end
        end
    end

    // The press is taken from the next-state value so that stop_pulse and the
    // debounced rising edge land on the same clock edge.
    assign press = btn_db_d & ~btn_db_q;

    // ------------------------------------------------------------------
    // Trial FSM
    // ------------------------------------------------------------------
    // The counter is loaded with the total delay minus one. The DELAY state
    // spends one more cycle at zero before it moves to LIT, so the LED comes
    // on exactly DELAY_MIN + (lfsr & DELAY_MASK) edges after the arm edge.
    assign delay_load = DELAY_BASE + {1'b0, (lfsr_q & DELAY_MASK)} - 17'd1;

    always_comb begin
        state_d       = state_q;
        dcnt_d        = dcnt_q;
        led_on_d      = led_on_q;
        start_pulse_d = 1'b0;
        stop_pulse_d  = 1'b0;
        false_start_d = false_start_q;

        case (state_q)
            ST_IDLE: begin
                led_on_d = 1'b0;
                if (arm) begin
                    state_d       = ST_DELAY;
                    dcnt_d        = delay_load;
                    false_start_d = 1'b0;
                end
            end

            ST_DELAY: begin
                // A press wins over the delay expiring in the same cycle.
                if (press) begin
                    state_d       = ST_IDLE;
                    dcnt_d        = '0;
                    false_start_d = 1'b1;
                end else if (dcnt_q == 17'd0) begin
                    state_d       = ST_LIT;
                    led_on_d      = 1'b1;
                    start_pulse_d = 1'b1;
                end else begin
                    dcnt_d = dcnt_q - 17'd1;
                end
            end

            ST_LIT: begin
                // No timeout: the LED stays lit until a fresh press.
                if (press) begin
                    state_d      = ST_IDLE;
                    led_on_d     = 1'b0;
                    stop_pulse_d = 1'b1;
                end
            end

            default: begin
                state_d  = ST_IDLE;
                dcnt_d   = '0;
                led_on_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q        <= LFSR_SEED;
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            db_cnt_q      <= '0;
            btn_db_q      <= 1'b0;
            state_q       <= ST_IDLE;
            dcnt_q        <= '0;
            led_on_q      <= 1'b0;
            start_pulse_q <= 1'b0;
            stop_pulse_q  <= 1'b0;
            false_start_q <= 1'b0;
        end else begin
            lfsr_q        <= lfsr_d;
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            db_cnt_q      <= db_cnt_d;
            btn_db_q      <= btn_db_d;
            state_q       <= state_d;
            dcnt_q        <= dcnt_d;
            led_on_q      <= led_on_d;
            start_pulse_q <= start_pulse_d;
            stop_pulse_q  <= stop_pulse_d;
            false_start_q <= false_start_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign led_on      = led_on_q;
    assign start_pulse = start_pulse_q;
    assign stop_pulse  = stop_pulse_q;
    assign btn_db      = btn_db_q;
    assign false_start = false_start_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_reaction_stimulus_gen.sv
module tb_reaction_stimulus_gen;

    localparam int          DB    = 4;
    localparam int          DMIN  = 10;
    localparam logic [15:0] DMASK = 16'h000F;

    logic clk        = 1'b0;
    logic rst        = 1'b1;
    logic arm        = 1'b0;
    logic button_raw = 1'b0;
    logic led_on, start_pulse, stop_pulse, btn_db, false_start, busy;

    int n_cmp    = 0;
    int n_mis    = 0;
    int edge_cnt = 0;

    logic [15:0] m_lfsr;
    int exp_start_q[$];
    int exp_stop_q[$];

    reaction_stimulus_gen #(
        .DEBOUNCE_CYCLES(DB),
        .DELAY_MIN      (DMIN),
        .DELAY_MASK     (DMASK)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .arm        (arm),
        .button_raw (button_raw),
        .led_on     (led_on),
        .start_pulse(start_pulse),
        .stop_pulse (stop_pulse),
        .btn_db     (btn_db),
        .false_start(false_start),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Reference LFSR
    always @(posedge clk or posedge rst) begin
        if (rst) m_lfsr <= 16'hACE1;
        else     m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock; outputs are sampled 1 time unit after the edge and any pulse
    // is matched against the scoreboard queues.
    task automatic step();
        int e;
        @(posedge clk);
        #1;
        if (start_pulse === 1'b1) begin
            if (exp_start_q.size() == 0) begin
                check("start_unexpected", start_pulse, 0);
            end else begin
                e = exp_start_q.pop_front();
                check("start_edge", edge_cnt, e);
                check("led_at_start", led_on, 1);
            end
        end
        if (stop_pulse === 1'b1) begin
            if (exp_stop_q.size() == 0) begin
                check("stop_unexpected", stop_pulse, 0);
            end else begin
                e = exp_stop_q.pop_front();
                check("stop_edge", edge_cnt, e);
                check("led_at_stop", led_on, 0);
                check("busy_at_stop", busy, 0);
            end
        end
    endtask

    task automatic wait_start(input int budget);
        int n = 0;
        while (exp_start_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        check("start_timeout", exp_start_q.size(), 0);
    endtask

    task automatic wait_stop(input int budget);
        int n = 0;
        while (exp_stop_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        check("stop_timeout", exp_stop_q.size(), 0);
    endtask

    // Arm sampled at the next edge K; LED expected at K + DMIN + (lfsr_K & mask).
    task automatic arm_trial();
        int k;
        arm = 1'b1;
        k   = edge_cnt + 1;
        exp_start_q.push_back(k + DMIN + int'(m_lfsr & DMASK));
        step();
        arm = 1'b0;
        check("busy_after_arm", busy, 1);
        check("fs_cleared_by_arm", false_start, 0);
    endtask

    // First sampling edge N = edge_cnt+1; stop expected at N + 1 + DB.
    task automatic press_and_expect_stop();
        button_raw = 1'b1;
        exp_stop_q.push_back(edge_cnt + 2 + DB);
        wait_stop(30);
    endtask

    task automatic release_button();
        button_raw = 1'b0;
        repeat (DB + 4) step();
        check("btn_released", btn_db, 0);
    endtask

    initial begin
        int hi_len[5] = '{1, 3, 2, 1, 3};

        // ---------------- reset state ----------------
        repeat (3) step();
        check("rst_led", led_on, 0);
        check("rst_start", start_pulse, 0);
        check("rst_stop", stop_pulse, 0);
        check("rst_btn_db", btn_db, 0);
        check("rst_fs", false_start, 0);
        check("rst_busy", busy, 0);
        check("rst_lfsr", dut.lfsr_q, 16'hACE1);
        rst = 1'b0;
        repeat (2) step();

        // ---------------- normal trial ----------------
        arm_trial();
        check("led_off_in_delay", led_on, 0);
        wait_start(40);
        step();
        check("start_one_cycle", start_pulse, 0);
        check("led_held", led_on, 1);
        repeat (18) step();
        press_and_expect_stop();
        release_button();

        // ---------------- false start ----------------
        arm_trial();
        button_raw = 1'b1;
        exp_start_q.delete();
        repeat (12) step();
        check("fs_set", false_start, 1);
        check("fs_busy", busy, 0);
        check("fs_led", led_on, 0);
        release_button();
        check("fs_sticky", false_start, 1);
        arm_trial();
        wait_start(40);
        repeat (3) step();
        press_and_expect_stop();
        release_button();

        // ---------------- bounce rejection ----------------
        arm_trial();
        wait_start(40);
        for (int i = 0; i < 5; i++) begin
            button_raw = 1'b1;
            repeat (hi_len[i]) step();
            button_raw = 1'b0;
            repeat (3) step();
        end
        repeat (6) step();
        check("bounce_led", led_on, 1);
        check("bounce_btn_db", btn_db, 0);
        press_and_expect_stop();
        release_button();

        // ---------------- held button ----------------
        button_raw = 1'b1;
        repeat (DB + 4) step();
        check("held_btn_db", btn_db, 1);
        check("held_idle", busy, 0);
        arm_trial();
        wait_start(40);
        repeat (10) step();
        check("held_led", led_on, 1);
        button_raw = 1'b0;
        repeat (DB + 4) step();
        check("held_release_led", led_on, 1);
        press_and_expect_stop();
        release_button();

        // ---------------- arm ignored while busy ----------------
        arm_trial();
        repeat (3) begin
            step();
            arm = 1'b1;
            step();
            arm = 1'b0;
        end
        wait_start(40);
        repeat (3) begin
            step();
            arm = 1'b1;
            step();
            arm = 1'b0;
        end
        check("arm_lit_led", led_on, 1);
        press_and_expect_stop();
        release_button();

        // ---------------- arm held: back-to-back trials ----------------
        arm = 1'b1;
        for (int t = 0; t < 3; t++) begin
            exp_start_q.push_back(edge_cnt + 1 + DMIN + int'(m_lfsr & DMASK));
            wait_start(40);
            if (t == 2) arm = 1'b0;
            repeat (5) step();
            press_and_expect_stop();
            button_raw = 1'b0;
        end
        repeat (DB + 4) step();
        check("b2b_idle", busy, 0);

        // ---------------- reset mid-LIT ----------------
        arm_trial();
        wait_start(40);
        repeat (3) step();
        #2;
        rst = 1'b1;
        #1;
        check("arst_led", led_on, 0);
        check("arst_busy", busy, 0);
        check("arst_start", start_pulse, 0);
        check("arst_stop", stop_pulse, 0);
        check("arst_fs", false_start, 0);
        check("arst_lfsr", dut.lfsr_q, 16'hACE1);
        repeat (2) step();
        rst = 1'b0;
        step();
        arm_trial();
        wait_start(40);
        repeat (4) step();
        press_and_expect_stop();
        release_button();

        check("start_q_empty", exp_start_q.size(), 0);
        check("stop_q_empty", exp_stop_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
